// File: rtl/sha256_job_arbiter_if.sv
// Requester fabric, hash engine and digest return signals of the SHA-256 job arbiter.
// The arbiter uses the slave view; the environment driving it uses the master view.
interface sha256_job_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    logic               core_ready;
    logic               core_start;
    logic               core_first;
    logic               core_last;
    logic               core_wvalid;
    logic [31:0]        core_wdata;
    logic               core_dvalid;
    logic [31:0]        core_ddata;

    logic               dig_valid;
    logic [31:0]        dig_data;
    logic [IDW-1:0]     dig_id;
    logic               busy;

    modport master (
        output req_valid, req_last, req_data, core_ready, core_dvalid, core_ddata,
        input  req_ready, core_start, core_first, core_last, core_wvalid, core_wdata,
        input  dig_valid, dig_data, dig_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, core_ready, core_dvalid, core_ddata,
        output req_ready, core_start, core_first, core_last, core_wvalid, core_wdata,
        output dig_valid, dig_data, dig_id, busy
    );
endinterface

// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one SHA-256 engine among NREQ requesters; a grant is held
// for a whole multi-block message and released after the 8-word digest has been returned.
module sha256_job_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input logic                 clk,
    input logic                 reset,
    sha256_job_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StWait, StDrain} state_e;

    state_e         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [3:0]     wcnt;
    logic [2:0]     dcnt;
    logic           first_flag;
    logic           blk_last;

    logic           any_req;
    logic [IDW-1:0] pick;
    logic           accept;
    logic [31:0]    lane;

    // Returns {found, index} of the first valid requester at or after ptr, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (valid[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign {any_req, pick} = rr_pick(bus.req_valid, rr_ptr);

    // The first word of a block also needs the engine to be ready for a new block.
    assign accept = (state == StLoad) && bus.req_valid[grant] &&
                    ((wcnt != 4'd0) || bus.core_ready);
    assign lane   = bus.req_data[32*int'(grant) +: 32];

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant] = 1'b1;
    end

    assign bus.busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= StIdle;
            rr_ptr          <= '0;
            grant           <= '0;
            wcnt            <= '0;
            dcnt            <= '0;
            first_flag      <= 1'b0;
            blk_last        <= 1'b0;
            bus.core_start  <= 1'b0;
            bus.core_first  <= 1'b0;
            bus.core_last   <= 1'b0;
            bus.core_wvalid <= 1'b0;
            bus.core_wdata  <= '0;
            bus.dig_valid   <= 1'b0;
            bus.dig_data    <= '0;
            bus.dig_id      <= '0;
        end else begin
            bus.core_start  <= 1'b0;
            bus.core_first  <= 1'b0;
            bus.core_last   <= 1'b0;
            bus.core_wvalid <= 1'b0;
            bus.dig_valid   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.core_ready && any_req) begin
                        grant      <= pick;
                        rr_ptr     <= (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
                        first_flag <= 1'b1;
                        state      <= StLoad;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        bus.core_wvalid <= 1'b1;
                        bus.core_wdata  <= lane;
                        wcnt            <= wcnt + 4'd1;
                        if (wcnt == 4'd0) begin
                            bus.core_start <= 1'b1;
                            bus.core_first <= first_flag;
                            bus.core_last  <= bus.req_last[grant];
                            blk_last       <= bus.req_last[grant];
                            first_flag     <= 1'b0;
                        end
                        if (wcnt == 4'd15) state <= blk_last ? StDrain : StWait;
                    end
                end
                StWait: begin
                    if (bus.core_ready) state <= StLoad;
                end
                StDrain: begin
                    if (bus.core_dvalid) begin
                        bus.dig_valid <= 1'b1;
                        bus.dig_data  <= bus.core_ddata;
                        bus.dig_id    <= grant;
                        dcnt          <= dcnt + 3'd1;
                        if (dcnt == 3'd7) state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Bench for sha256_job_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a message-level reference model.
module tb_sha256_job_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha256_job_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    sha256_job_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester agents: each holds one message of up to 3 blocks.
    logic [31:0] wbuf [NREQ][48];
    int wlen [NREQ];
    int wpos [NREQ];
    int hold [NREQ];
    int stall_at [NREQ];
    int stall_pct, cr_pct, dv_pct, cr_hold;

    logic [31:0]    wlog [$];
    int             wcyc [$];
    logic [1:0]     slog [$];
    logic [IDW-1:0] dlog [$];

    // Reference model state, in message terms.
    int  m_owner = -1;
    int  m_ptr, m_pos, m_digs;
    bit  m_first, m_final, m_between, m_drain;
    bit  chk_en = 1'b0;
    logic        e_wvalid, e_start, e_first, e_last, e_dvalid, e_zero;
    logic [31:0] e_wdata, e_ddata;
    logic [IDW-1:0] e_did;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        r = '0;
        if (m_owner >= 0 && !m_between && !m_drain && bus.req_valid[m_owner] &&
            (m_pos != 0 || bus.core_ready))
            r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic model_update();
        logic [NREQ-1:0] rdy;
        bit found;
        int c;
        rdy = exp_ready();
        e_wvalid = 0; e_start = 0; e_first = 0; e_last = 0; e_dvalid = 0; e_zero = 0;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_pos = 0; m_digs = 0;
            m_first = 0; m_final = 0; m_between = 0; m_drain = 0;
            e_zero = 1; e_wdata = '0; e_ddata = '0; e_did = '0;
            chk_en = 1'b1;
        end else if (m_owner < 0) begin
            if (bus.core_ready && bus.req_valid != '0) begin
                found = 0;
                for (int k = 0; k < int'(NREQ); k++) begin
                    c = (m_ptr + k) % int'(NREQ);
                    if (!found && bus.req_valid[c]) begin
                        m_owner = c;
                        found = 1;
                    end
                end
                m_ptr = (m_owner + 1) % int'(NREQ);
                m_first = 1; m_pos = 0;
            end
        end else if (m_drain) begin
            if (bus.core_dvalid) begin
                e_dvalid = 1; e_ddata = bus.core_ddata; e_did = IDW'(m_owner);
                m_digs++;
                if (m_digs == 8) begin
                    m_owner = -1; m_drain = 0; m_digs = 0;
                end
            end
        end else if (m_between) begin
            if (bus.core_ready) m_between = 0;
        end else if (rdy[m_owner]) begin
            e_wvalid = 1;
            e_wdata  = bus.req_data[32*m_owner +: 32];
            if (m_pos == 0) begin
                e_start = 1; e_first = m_first; e_last = bus.req_last[m_owner];
                m_final = bus.req_last[m_owner]; m_first = 0;
            end
            m_pos++;
            if (m_pos == 16) begin
                m_pos = 0;
                if (m_final) m_drain = 1;
                else m_between = 1;
            end
        end
    endtask

    // Compare, log and advance the model once per cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy", bus.busy, m_owner >= 0);
                chk("req_ready", bus.req_ready, exp_ready());
                chk("core_wvalid", bus.core_wvalid, e_wvalid);
                chk("core_start", bus.core_start, e_start);
                chk("core_first", bus.core_first, e_first);
                chk("core_last", bus.core_last, e_last);
                chk("dig_valid", bus.dig_valid, e_dvalid);
                if (e_wvalid || e_zero) chk("core_wdata", bus.core_wdata, e_wdata);
                if (e_dvalid || e_zero) begin
                    chk("dig_data", bus.dig_data, e_ddata);
                    chk("dig_id", bus.dig_id, e_did);
                end
            end
            if (bus.core_wvalid === 1'b1) begin
                wlog.push_back(bus.core_wdata);
                wcyc.push_back(cyc);
            end
            if (bus.core_start === 1'b1) slog.push_back({bus.core_first, bus.core_last});
            if (bus.dig_valid === 1'b1) dlog.push_back(bus.dig_id);
            model_update();
        end
    end

    task automatic drive();
        logic act;
        for (int i = 0; i < int'(NREQ); i++) begin
            act = wpos[i] < wlen[i];
            bus.req_valid[i] = act && hold[i] == 0 && ($urandom_range(99) >= stall_pct);
            bus.req_data[32*i +: 32] = act ? wbuf[i][wpos[i]] : 32'h0;
            bus.req_last[i] = act && (wpos[i] / 16 == wlen[i] / 16 - 1);
        end
        bus.core_ready  = cr_hold == 0 && $urandom_range(99) < cr_pct;
        bus.core_dvalid = $urandom_range(99) < dv_pct;
        bus.core_ddata  = $urandom;
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = bus.req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (cr_hold > 0) cr_hold--;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (hold[i] > 0) hold[i]--;
            if (acc[i]) begin
                wpos[i]++;
                if (wpos[i] == stall_at[i]) begin
                    hold[i] = 3;
                    stall_at[i] = -1;
                end
            end
        end
        drive();
    endtask

    task automatic start_msg(input int r, input int nblk, input int base);
        wlen[r] = 16 * nblk;
        wpos[r] = 0;
        for (int k = 0; k < wlen[r]; k++) wbuf[r][k] = (base < 0) ? $urandom : 32'(base + k);
        drive();
    endtask

    function automatic bit all_done();
        bit d;
        d = 1;
        for (int i = 0; i < int'(NREQ); i++) if (wpos[i] < wlen[i]) d = 0;
        return d;
    endfunction

    task automatic run_quiet(input string nm, input int budget);
        int n;
        n = 0;
        while (!(all_done() && bus.busy === 1'b0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, budget);
        end
        step();
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); slog.delete(); dlog.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) begin
            wlen[i] = 0; wpos[i] = 0; hold[i] = 0;
        end
        drive();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit restarted;
        int rr_exp [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < int'(NREQ); i++) begin
            wlen[i] = 0; wpos[i] = 0; hold[i] = 0; stall_at[i] = -1;
        end
        stall_pct = 0; cr_pct = 100; dv_pct = 0; cr_hold = 0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
        bus.core_ready = 1'b0; bus.core_dvalid = 1'b0; bus.core_ddata = '0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_core_wvalid", bus.core_wvalid, 0);
        chk("rst_core_start", bus.core_start, 0);
        chk("rst_dig_valid", bus.dig_valid, 0);

        // Single block from requester 2; digest words offered on every cycle.
        dv_pct = 100;
        clear_logs();
        start_msg(2, 1, 0);
        run_quiet("single", 200);
        chk("single_words", wlog.size(), 16);
        foreach (wlog[k]) chk("single_word", wlog[k], k);
        if (wcyc.size() == 16) chk("single_span", wcyc[15] - wcyc[0], 15);
        chk("single_starts", slog.size(), 1);
        if (slog.size() > 0) chk("single_qual", slog[0], 2'b11);
        chk("single_digests", dlog.size(), 8);
        foreach (dlog[k]) chk("single_dig_id", dlog[k], 2);
        chk("single_busy", bus.busy, 0);

        // Two-block message from requester 0 with the engine stalled between blocks.
        clear_logs();
        start_msg(0, 2, 32'h100);
        n = 0;
        while (wpos[0] < 16 && n < 200) begin
            step();
            n++;
        end
        cr_hold = 10;
        drive();
        run_quiet("two_block", 300);
        chk("two_words", wlog.size(), 32);
        foreach (wlog[k]) chk("two_word", wlog[k], 32'h100 + k);
        if (wcyc.size() == 32) chk("two_gap", wcyc[16] - wcyc[15], 12);
        chk("two_starts", slog.size(), 2);
        if (slog.size() == 2) begin
            chk("two_qual0", slog[0], 2'b10);
            chk("two_qual1", slog[1], 2'b01);
        end
        chk("two_digests", dlog.size(), 8);
        foreach (dlog[k]) chk("two_dig_id", dlog[k], 0);

        // Round robin from a fresh pointer with all requesters active.
        pulse_reset();
        clear_logs();
        for (int r = 0; r < int'(NREQ); r++) start_msg(r, 1, -1);
        restarted = 0;
        n = 0;
        while (dlog.size() < 40 && n < 800) begin
            step();
            n++;
            if (!restarted && wpos[0] == wlen[0]) begin
                start_msg(0, 1, -1);
                restarted = 1;
            end
        end
        chk("rr_count", dlog.size() >= 40, 1);
        for (int m = 0; m < 5; m++)
            if (dlog.size() > 8 * m) chk("rr_order", dlog[8*m], rr_exp[m]);
        run_quiet("rr", 200);

        // Requester 1 stalls for three cycles after its sixth word.
        clear_logs();
        stall_at[1] = 6;
        start_msg(1, 1, 32'h200);
        run_quiet("stall", 200);
        chk("stall_words", wlog.size(), 16);
        foreach (wlog[k]) chk("stall_word", wlog[k], 32'h200 + k);
        if (wcyc.size() == 16) chk("stall_bubbles", wcyc[15] - wcyc[0] + 1 - 16, 3);

        // Reset in the middle of a block, then a fresh request from requester 3.
        clear_logs();
        start_msg(0, 1, -1);
        n = 0;
        while (wpos[0] < 8 && n < 100) begin
            step();
            n++;
        end
        chk("mid_reached", wpos[0], 8);
        pulse_reset();
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_core_wvalid", bus.core_wvalid, 0);
        clear_logs();
        start_msg(3, 1, -1);
        run_quiet("after_reset", 200);
        chk("after_reset_starts", slog.size(), 1);
        if (slog.size() > 0) chk("after_reset_qual", slog[0], 2'b11);
        if (dlog.size() > 0) chk("after_reset_dig_id", dlog[0], 3);

        // Randomized traffic with occasional resets.
        stall_pct = 20; cr_pct = 70; dv_pct = 40;
        clear_logs();
        for (int t = 0; t < 4000; t++) begin
            for (int r = 0; r < int'(NREQ); r++)
                if (wpos[r] >= wlen[r] && $urandom_range(9) == 0)
                    start_msg(r, int'($urandom_range(3, 1)), -1);
            if ($urandom_range(999) == 0) pulse_reset();
            else step();
        end
        chk("rand_digests", dlog.size() > 0, 1);
        stall_pct = 0; cr_pct = 100; dv_pct = 100;
        run_quiet("final_drain", 600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha256_job_arbiter.md
Name: sha256_job_arbiter

Overview:
- Shares one SHA-256 hash engine among NREQ requesters, each submitting a multi-block message as 32-bit words.
- Grants are round-robin and held for the whole message, because chaining state lives in the engine.
- Sequences engine start/first/last qualifiers and returns the 8-word digest tagged with the requester id.
- Sits between the requester fabric and the hash engine's control/data inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester id (clog2(NREQ), minimum 1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  NREQ  requester i has a word on its lane / wants service
req_last  in  NREQ  block currently offered by requester i is the final block of its message
req_data  in  32*NREQ  word lanes; lane i = bits [32i+31:32i]
req_ready  out  NREQ  word on lane i accepted this cycle (combinational)
core_ready  in  1  engine can accept a new block
core_start  out  1  one-cycle pulse with the first word of each block
core_first  out  1  qualifier valid with core_start: block is the first of a message
core_last  out  1  qualifier valid with core_start: block is the last of a message
core_wvalid  out  1  core_wdata valid
core_wdata  out  32  message word to engine
core_dvalid  in  1  engine digest word valid
core_ddata  in  32  engine digest word, H0 first
dig_valid  out  1  digest word valid to requesters
dig_data  out  32  digest word
dig_id  out  IDW  owner of digest word
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset state:
  - state=IDLE, rr pointer=0, word count=0, digest count=0, first_flag=0.
  - All outputs 0; requester 0 has top priority after reset.
- States are IDLE, LOAD, WAIT, DRAIN.
- IDLE:
  - When core_ready=1 and any req_valid=1, grant g = first set req_valid at or after pointer, wrapping modulo NREQ.
  - Pointer <= (g+1) mod NREQ. first_flag <= 1. Go to LOAD.
  - No grant while core_ready=0.
- LOAD:
  - req_ready[g] = req_valid[g] && (wcnt!=0 || core_ready). All other req_ready bits = 0.
  - Each accepted word increments wcnt (4-bit, 0..15).
  - The word is registered onto core_wdata with core_wvalid=1 one cycle later.
  - When wcnt==0 is accepted: core_start=1 registered alongside that word; core_first=first_flag; core_last=req_last[g] (sampled that cycle and held as blk_last). first_flag then clears.
  - Requester stalls (req_valid[g]=0) insert bubbles: core_wvalid=0, no timeout.
  - After word 15 is accepted: wcnt wraps to 0. Go to DRAIN if blk_last=1, else WAIT.
- WAIT (non-final block):
  - Grant held.
  - core_ready sampling starts the cycle after entering WAIT.
  - When core_ready=1, go to LOAD for the next block of the same requester.
- DRAIN:
  - Each core_dvalid=1 cycle registers dig_valid=1, dig_data=core_ddata, dig_id=g; dcnt increments.
  - After the 8th word: dcnt=0, release grant, go to IDLE.
  - The next grant can occur at the earliest on the cycle after returning to IDLE.
- core_dvalid outside DRAIN is ignored: no dig_valid.
- Grant is never preempted, whatever the other requesters' activity.
- A new req_valid arriving during service waits for IDLE.
- Simultaneous requests are resolved strictly by rr order.
- Reset in any state aborts immediately. Outputs go to 0 next cycle; the partial block is discarded, and the engine must be reset by the same signal.
- Latencies:
  - Request to first core_wvalid: 2 cycles minimum (IDLE grant cycle, LOAD accept cycle, registered output).
  - Digest: 1 cycle after core_dvalid.

Test Plan:
- Single block: req 2 offers 16 words 0x00000000..0x0000000F with req_last=1 and core_ready=1 → core_start/core_first/core_last=1 with word 0; 16 consecutive core_wvalid. 8 injected digest words appear on dig_data with dig_id=2, one cycle late. busy drops after the 8th.
- Two-block message: req 0 with req_last=0 then 1; core_ready held 0 for 10 cycles in WAIT → second block's core_start has core_first=0, core_last=1. No words are sent while core_ready=0. Grant stays on req 0.
- Round-robin: all 4 request continuously, single blocks → service order 0,1,2,3,0. Each dig_id matches its owner.
- Stall: req 1 drops req_valid for 3 cycles after word 5 → exactly 3 core_wvalid=0 bubbles; word order intact; wcnt resumes at 6.
- Reset mid-LOAD after word 7 → next cycle: busy=0, all req_ready=0, core_wvalid=0. A subsequent request from req 3 alone is granted with core_first=1.
- Spurious core_dvalid in IDLE or LOAD → no dig_valid pulse.
